// File: rtl/program_loader_if.sv
// Stream-in / RAM-write bus of the boot program loader.
// The slave side is the loader itself; master is the upstream source plus RAM observer.
interface program_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
);
  logic                 s_valid;
  logic [WORD_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: zero-fills the MCPU RAM, streams a program in from address 0,
// and holds the CPU in reset until a complete program is resident.
module program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  program_loader_if.slave      bus,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_SIZE:0]   word_count,
  output logic [WORD_SIZE-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, DRAIN, RUN, ERROR
  } state_e;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_SIZE - 1);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE:0]   word_count_q, word_count_d;
  logic [WORD_SIZE-1:0] checksum_q, checksum_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 s_ready_q, s_ready_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d      = CLEAR;
          mem_we_d     = 1'b1;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          addr_d       = '0;
          word_count_d = '0;
          checksum_d   = '0;
        end
      end
      CLEAR: begin
        // mem_addr_q is the address on the bus now; once the top word is out, loading begins.
        if (mem_addr_q == LAST_ADDR) begin
          state_d = LOAD;
          addr_d  = '0;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_SIZE'(1);
          mem_wdata_d = '0;
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_wdata_d  = bus.s_data;
          addr_d       = addr_q + ADDR_SIZE'(1);
          word_count_d = word_count_q + (ADDR_SIZE+1)'(1);
          checksum_d   = checksum_q + bus.s_data;
          if (bus.s_last)                state_d = DRAIN;
          else if (addr_q == LAST_ADDR)  state_d = ERROR;
        end
      end
      DRAIN:   state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered off the next state so they track state_q exactly.
    s_ready_d   = (state_d == LOAD);
    cpu_reset_d = (state_d != RUN);
    busy_d      = (state_d == CLEAR) || (state_d == LOAD) || (state_d == DRAIN);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      s_ready_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      s_ready_q    <= s_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign word_count    = word_count_q;
  assign checksum      = checksum_q;

endmodule
